lock_spec_checker: RTL and testbench

- Per-cycle checker and next-state model for a bank of NLOCKS binary locks.
- Each cycle it takes two inputs:
  - the observed lock state vector (monitor);
  - one 2-bit operation per lock (system).
- It produces the legal next lock state plus a violation flag.
- Sits beside the lock arbiter in the runtime-monitor path; the out bus feeds the property-checking logic.

---
 rtl/lock_spec_checker.sv | 30 +++
 tb/tb_lock_spec_checker.sv | 62 ++++++
 2 files changed

// File: rtl/lock_spec_checker.sv
// lock_spec_checker: per-lock next-state/violation checker; LOCK_STICKY_ERR_EN makes the violation bit sticky until rst
module lock_spec_checker #(
    parameter int NLOCKS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [NLOCKS-1:0]     monitor,
    input  logic [2*NLOCKS-1:0]   system,
    output logic [NLOCKS:0]       out
);
    logic [NLOCKS-1:0] nxt;
    logic [NLOCKS-1:0] err;
    logic              vbit;
    for (genvar i = 0; i < NLOCKS; i++) begin : g_lock
        logic [1:0] op;
        assign op     = system[2*(NLOCKS-1-i) +: 2];
        assign nxt[i] = (op == 2'b10) ? 1'b1 : (op == 2'b01) ? 1'b0 : monitor[i];
        assign err[i] = (op == 2'b11) | ((op == 2'b10) & monitor[i]) | ((op == 2'b01) & ~monitor[i]);
    end
`ifdef LOCK_STICKY_ERR_EN
    assign vbit = (|err) | out[NLOCKS];
`else
    assign vbit = |err;
`endif
    always_ff @(posedge clk) begin
        if (rst) out <= '0;
        else if (in_valid) out <= {vbit, nxt};
    end
endmodule

// File: tb/tb_lock_spec_checker.sv
// tb_lock_spec_checker: directed-vector bench for lock_spec_checker with NLOCKS=3
module tb_lock_spec_checker;
`ifdef LOCK_STICKY_ERR_EN
    localparam logic [3:0] STK = 4'b1000;
`else
    localparam logic [3:0] STK = 4'b0000;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] monitor = '0;
    logic [5:0] system = '0;
    logic [3:0] out;
    int compared = 0;
    int mismatched = 0;

    lock_spec_checker #(.NLOCKS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .monitor(monitor), .system(system), .out(out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic [2:0] m,
                        input logic [5:0] s, input logic [3:0] e, input string tag);
        @(negedge clk);
        rst = r;
        in_valid = v;
        monitor = m;
        system = s;
        @(posedge clk);
        #1;
        compared++;
        assert (out === e) else begin
            mismatched++;
            $error("FAIL %s: out=%b expected=%b", tag, out, e);
        end
    endtask

    initial begin
        step(1, 0, 3'b000, 6'b000000, 4'b0000, "reset");
        step(0, 0, 3'b111, 6'b101010, 4'b0000, "hold_after_reset");
        step(0, 1, 3'b000, 6'b000000, 4'b0000, "idle");
        step(0, 1, 3'b000, 6'b100000, 4'b0001, "acquire");
        step(0, 1, 3'b001, 6'b100000, 4'b1001, "double_acquire");
        step(0, 1, 3'b000, 6'b000000, 4'b0000 | STK, "sticky_after_violation");
        step(1, 0, 3'b000, 6'b000000, 4'b0000, "reset_clears_sticky");
        step(0, 1, 3'b001, 6'b101100, 4'b1001, "mixed_acq_reserved");
        step(1, 0, 3'b000, 6'b000000, 4'b0000, "reset_mid");
        step(0, 1, 3'b001, 6'b010010, 4'b0100, "mixed_unlock_lock");
        step(0, 1, 3'b000, 6'b010000, 4'b1000, "release_free");
        step(0, 0, 3'b111, 6'b111111, 4'b1000, "hold_invalid");
        step(0, 1, 3'b000, 6'b101010, 4'b0111 | STK, "acquire_all");
        step(0, 1, 3'b111, 6'b010101, 4'b0000 | STK, "release_all");
        step(0, 1, 3'b101, 6'b111111, 4'b1101, "reserved_all");
        step(1, 1, 3'b000, 6'b100000, 4'b0000, "rst_priority");
        step(0, 1, 3'b010, 6'b000001, 4'b1010, "first_after_reset");
        step(0, 1, 3'b110, 6'b100100, 4'b0101 | STK, "independent_locks");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
